rc5_key_scheduler: RTL and testbench

RC5_KEY_SCHEDULER -- requirements
Module: rc5_key_scheduler

---
 rtl/rc5_key_scheduler.sv | 152 +++++++++++++++
 tb/tb_rc5_key_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_key_scheduler.sv
// RC-5 key scheduler: latches key press edges, grants them round-robin and hands
// 14-bit frames to an RC-5 transmitter. Define RC5_AUTOREPEAT_EN for auto-repeat.
//
// state     | meaning
// IDLE      | no frame in progress, waiting for a pending request
// GRANT     | pick next request round-robin, build tx_frame
// START     | one-cycle tx_start pulse
// WAIT_BUSY | waiting for the transmitter to accept (255-cycle timeout)
// WAIT_DONE | frame on air, waiting for tx_busy to drop
// GAP       | enforced idle time between frames
module rc5_key_scheduler #(
    parameter int          NUM_KEYS   = 4,
    parameter logic [4:0]  RC5_ADDR   = 5'd0,
    parameter logic [5:0]  CMD_BASE   = 6'd0,
    parameter logic [15:0] GAP_CYCLES = 16'd1000
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [NUM_KEYS-1:0] key_level,
    input  logic                tx_busy,
    output logic                tx_start,
    output logic [13:0]         tx_frame,
    output logic [NUM_KEYS-1:0] pending,
    output logic                active
);

    localparam int PTR_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GRANT     = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;

    logic [2:0]          state;
    logic [NUM_KEYS-1:0] key_prev;
    logic                armed;
    logic [PTR_W-1:0]    rr_ptr;
    logic                toggle;
    logic [7:0]          wb_timer;
    logic [15:0]         gap_cnt;
`ifdef RC5_AUTOREPEAT_EN
    logic [PTR_W-1:0]    last_key;
`endif

    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] clr_mask;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    idx_p;
    logic [5:0]          grant_cmd;
    int                  idx;

    // armed blocks edge detection in the first cycle after reset, so a key
    // already held at release is not mistaken for a press.
    assign rise = key_level & ~key_prev & {NUM_KEYS{armed}};

    always_comb begin
        grant_idx = '0;
        idx       = 0;
        idx_p     = '0;
        // Walk from the farthest candidate back to rr_ptr so the nearest wins.
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_KEYS)
                idx = idx - NUM_KEYS;
            idx_p = PTR_W'(idx);
            if (pending[idx_p])
                grant_idx = idx_p;
        end
    end

    always_comb begin
        clr_mask = '0;
        if (state == S_GRANT)
            clr_mask[grant_idx] = 1'b1;
    end

    assign grant_cmd = CMD_BASE + 6'(grant_idx);
    assign tx_start  = (state == S_START);
    assign active    = (state != S_IDLE);

    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
            state    <= S_IDLE;
            key_prev <= '0;
            armed    <= 1'b0;
            pending  <= '0;
            rr_ptr   <= '0;
            toggle   <= 1'b0;
            tx_frame <= {2'b11, 1'b0, RC5_ADDR, CMD_BASE};
            wb_timer <= '0;
            gap_cnt  <= '0;
`ifdef RC5_AUTOREPEAT_EN
            last_key <= '0;
`endif
        end else begin
            armed    <= 1'b1;
            key_prev <= key_level;
            // A new edge on the bit being granted keeps it set.
            pending  <= (pending & ~clr_mask) | rise;
            case (state)
                S_IDLE: begin
                    if (|pending)
                        state <= S_GRANT;
                end
                S_GRANT: begin
                    rr_ptr   <= (grant_idx == PTR_W'(NUM_KEYS - 1)) ? '0 : grant_idx + 1'b1;
                    toggle   <= ~toggle;
                    tx_frame <= {2'b11, ~toggle, RC5_ADDR, grant_cmd};
`ifdef RC5_AUTOREPEAT_EN
                    last_key <= grant_idx;
`endif
                    state    <= S_START;
                end
                S_START: begin
                    wb_timer <= 8'd254;
                    state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (wb_timer == 8'd0) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        wb_timer <= wb_timer - 8'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_CYCLES - 16'd1) begin
`ifdef RC5_AUTOREPEAT_EN
                        state <= key_level[last_key] ? S_START : S_IDLE;
`else
                        state <= S_IDLE;
`endif
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_key_scheduler.sv
// Self-checking bench for rc5_key_scheduler: table vectors, directed corner
// sequences and randomized press batches against a transaction-level model.
module tb_rc5_key_scheduler;

    localparam int NK = 4;
    localparam int G  = 12;

    logic          clk = 1'b0;
    logic          n_reset;
    logic [NK-1:0] key_level;
    logic          tx_busy;
    logic          tx_start;
    logic [13:0]   tx_frame;
    logic [NK-1:0] pending;
    logic          active;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [13:0] rec_q[$];
    int          rec_cyc[$];
    int          fall_q[$];
    logic [13:0] exp_q[$];

    int busy_dly = 2;
    int busy_len = 20;
    bit busy_en  = 1'b1;

    int m_rr  = 0;
    bit m_tog = 1'b0;

    typedef struct packed {
        logic [NK-1:0]      mask;
        logic [31:0]        n;
        logic [3:0][13:0]   f;
    } vec_t;

    vec_t tbl[5];

    rc5_key_scheduler #(
        .NUM_KEYS  (NK),
        .RC5_ADDR  (5'd0),
        .CMD_BASE  (6'd0),
        .GAP_CYCLES(16'(G))
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .key_level(key_level),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_frame (tx_frame),
        .pending  (pending),
        .active   (active)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        if (tx_start === 1'b1) begin
            rec_q.push_back(tx_frame);
            rec_cyc.push_back(cyc);
        end
    end

    // Transmitter stand-in: busy rises busy_dly cycles after tx_start.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && busy_en) begin
                repeat (busy_dly) @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
                fall_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] frame_of(input int key, input bit tog);
        return {2'b11, tog, 5'd0, 6'(key)};
    endfunction

    function automatic vec_t mk(input logic [NK-1:0] mask, input int n,
                                input logic [13:0] f0, input logic [13:0] f1,
                                input logic [13:0] f2, input logic [13:0] f3);
        vec_t v;
        v.mask = mask;
        v.n    = 32'(n);
        v.f    = {f3, f2, f1, f0};
        return v;
    endfunction

    // Every requested key is served once, round-robin from the last grant.
    task automatic model_serve(input logic [NK-1:0] mask_in);
        logic [NK-1:0] mask;
        int idx;
        mask = mask_in;
        while (mask != '0) begin
            for (int k = 0; k < NK; k++) begin
                idx = (m_rr + k) % NK;
                if (mask[idx]) begin
                    m_tog = ~m_tog;
                    exp_q.push_back(frame_of(idx, m_tog));
                    mask[idx] = 1'b0;
                    m_rr = (idx + 1) % NK;
                    break;
                end
            end
        end
    endtask

    task automatic do_reset();
        key_level = '0;
        n_reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rec_q.delete();
        rec_cyc.delete();
        fall_q.delete();
        exp_q.delete();
        m_rr  = 0;
        m_tog = 1'b0;
    endtask

    task automatic press(input logic [NK-1:0] mask, input int hold);
        @(posedge clk);
        #1 key_level = mask;
        repeat (hold) @(posedge clk);
        #1 key_level = '0;
    endtask

    task automatic wait_quiet(input int max, input string name);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (!(active === 1'b0 && pending === '0) && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_quiet"}, 32'(n < max), 32'd1);
    endtask

    task automatic wait_busy_high(input int max, input string name);
        int n;
        n = 0;
        while (tx_busy !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy"}, 32'(n < max), 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic compare_frames(input string name);
        check({name, "_count"}, 32'(rec_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++)
            check(name, 32'(rec_q[i]), 32'(exp_q[i]));
        rec_q.delete();
        rec_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int rise_c;
        int t0;
        int hold_exp;
        logic [NK-1:0] m;

        tbl[0] = mk(4'b0010, 1, 14'h3801, 14'h0,    14'h0,    14'h0);
        tbl[1] = mk(4'b0101, 2, 14'h3800, 14'h3002, 14'h0,    14'h0);
        tbl[2] = mk(4'b1000, 1, 14'h3803, 14'h0,    14'h0,    14'h0);
        tbl[3] = mk(4'b1100, 2, 14'h3802, 14'h3003, 14'h0,    14'h0);
        tbl[4] = mk(4'b1111, 4, 14'h3800, 14'h3001, 14'h3802, 14'h3003);

        // Reset values while reset is held, with keys pressed.
        n_reset   = 1'b1;
        key_level = 4'b1010;
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_frame", 32'(tx_frame), 32'(frame_of(0, 1'b0)));
        check("rst_pending",  32'(pending),  32'd0);
        check("rst_active",   32'(active),   32'd0);

        foreach (tbl[i]) begin
            do_reset();
            press(tbl[i].mask, 1);
            wait_quiet(2000, "tbl");
            check("tbl_count", 32'(rec_q.size()), tbl[i].n);
            for (int j = 0; j < rec_q.size() && j < 4; j++)
                check("tbl_frame", 32'(rec_q[j]), 32'(tbl[i].f[j]));
        end

        // Press-to-start latency and frame contents for a single key.
        do_reset();
        @(posedge clk);
        #1 key_level = 4'b0010;
        rise_c = cyc;
        @(posedge clk);
        #1 key_level = '0;
        wait_quiet(1000, "lat");
        check("lat_count", 32'(rec_q.size()), 32'd1);
        if (rec_q.size() > 0) begin
            check("lat_cycles", 32'(rec_cyc[0] - rise_c), 32'd3);
            check("lat_frame",  32'(rec_q[0]), 32'h3801);
        end

        // Two keys at once: both served, gap honoured before the second.
        do_reset();
        press(4'b0101, 1);
        wait_quiet(2000, "pair");
        check("pair_count", 32'(rec_q.size()), 32'd2);
        if (rec_q.size() == 2 && fall_q.size() > 0) begin
            check("pair_f0", 32'(rec_q[0]), 32'h3800);
            check("pair_f1", 32'(rec_q[1]), 32'h3002);
            check("pair_gap", 32'(rec_cyc[1] - fall_q[0] >= G), 32'd1);
        end

        // Transmitter never answers: timeout, gap, back to idle.
        do_reset();
        busy_en = 1'b0;
        press(4'b0001, 1);
        repeat (8) @(negedge clk);
        check("to_start", 32'(rec_q.size()), 32'd1);
        if (rec_q.size() > 0) begin
            t0 = rec_cyc[0];
            wait_cyc(t0 + 255);
            check("to_active_wait", 32'(active), 32'd1);
            wait_cyc(t0 + 256 + G - 1);
            check("to_active_gap", 32'(active), 32'd1);
            wait_cyc(t0 + 256 + G);
            check("to_active_idle", 32'(active), 32'd0);
            repeat (20) @(negedge clk);
            check("to_no_retry", 32'(rec_q.size()), 32'd1);
        end
        busy_en = 1'b1;

        // Key held across several frame times.
        do_reset();
`ifdef RC5_AUTOREPEAT_EN
        hold_exp = 3;
`else
        hold_exp = 1;
`endif
        press(4'b1000, 90);
        wait_quiet(2000, "hold");
        check("hold_count", 32'(rec_q.size()), 32'(hold_exp));
        for (int j = 0; j < rec_q.size(); j++)
            check("hold_frame", 32'(rec_q[j]), 32'h3803);

        // Reset during WAIT_DONE with a re-press pending; key held through release.
        do_reset();
        press(4'b0001, 2);
        wait_busy_high(20, "rstmid");
        repeat (3) @(posedge clk);
        #1 key_level = 4'b0001;
        repeat (2) @(negedge clk);
        check("rstmid_pend", 32'(pending[0]), 32'd1);
        @(posedge clk);
        #1 n_reset = 1'b1;
        @(negedge clk);
        check("rstmid_start",  32'(tx_start), 32'd0);
        check("rstmid_frame",  32'(tx_frame), 32'h3000);
        check("rstmid_pclr",   32'(pending),  32'd0);
        check("rstmid_active", 32'(active),   32'd0);
        @(posedge clk);
        #1 n_reset = 1'b0;
        @(negedge clk);
        check("rstmid_rel_start", 32'(tx_start), 32'd0);
        repeat (80) @(negedge clk);
        check("rstmid_noframe", 32'(rec_q.size()), 32'd1);
        check("rstmid_held",    32'(pending),      32'd0);
        rec_q.delete();
        rec_cyc.delete();
        key_level = '0;
        press(4'b0001, 1);
        wait_quiet(1000, "rstmid_new");
        check("rstmid_new_n", 32'(rec_q.size()), 32'd1);
        if (rec_q.size() > 0)
            check("rstmid_new_f", 32'(rec_q[0]), 32'h3800);

        // Re-press during a frame, plus a repeated edge on an already pending key.
        do_reset();
        press(4'b0001, 1);
        model_serve(4'b0001);
        wait_busy_high(20, "repress");
        repeat (3) @(posedge clk);
        #1 key_level = 4'b0011;
        @(posedge clk);
        #1 key_level = '0;
        @(posedge clk);
        #1 key_level = 4'b0010;
        @(posedge clk);
        #1 key_level = '0;
        model_serve(4'b0011);
        wait_quiet(3000, "repress");
        compare_frames("repress");

        // Randomized press batches against the model.
        do_reset();
        for (int it = 0; it < 12; it++) begin
            m        = NK'($urandom_range(1, (1 << NK) - 1));
            busy_dly = $urandom_range(1, 4);
            busy_len = $urandom_range(1, 30);
            press(m, $urandom_range(1, 4));
            model_serve(m);
            wait_quiet(3000, "rand");
            compare_frames("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
